// File: rtl/rv32i_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg
//   Shared definitions for the multicycle RV32I control path: major opcode
//   values, controller state encoding, PC / write-back source selects, trap
//   cause codes and the instruction classes produced by ctrl_decoder.
// ---------------------------------------------------------------------------
package rv32i_pkg;

    // RV32I major opcodes (IR[6:0])
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } ctrl_state_t;

    typedef enum logic [1:0] {
        PCS_PLUS4  = 2'd0,
        PCS_BRANCH = 2'd1,   // PC + imm (JAL, taken branch)
        PCS_JALR   = 2'd2    // (rs1 + imm) & ~1
    } pc_sel_t;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2,
        WB_IMM  = 2'd3
    } wb_sel_t;

    typedef enum logic [1:0] {
        TC_NONE    = 2'd0,
        TC_ILLEGAL = 2'd1,
        TC_IMEM_TO = 2'd2,
        TC_DMEM_TO = 2'd3
    } trap_cause_t;

    typedef enum logic [3:0] {
        IC_ALU,      // OP, OP-IMM, AUIPC: ALU result written back
        IC_LOAD,
        IC_STORE,
        IC_BRANCH,
        IC_JAL,
        IC_JALR,
        IC_LUI,
        IC_NOP       // FENCE, SYSTEM: retire with PC+4 only
    } instr_class_t;

endpackage

// File: rtl/ctrl_decoder.sv
// ---------------------------------------------------------------------------
// ctrl_decoder
//   Combinational opcode classifier for the multicycle controller.
//   Ports:
//     opcode     in   7  IR[6:0]
//     iclass     out  4  instr_class_t encoding of the instruction
//     alu_src_a  out  1  0=rs1, 1=PC
//     alu_src_b  out  1  0=rs2, 1=imm
//     wb_sel     out  2  write-back source for classes that write rd
//     legal      out  1  opcode is one of the 11 RV32I major opcodes
// ---------------------------------------------------------------------------
module ctrl_decoder
    import rv32i_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [3:0] iclass,
    output logic       alu_src_a,
    output logic       alu_src_b,
    output logic [1:0] wb_sel,
    output logic       legal
);

    always_comb begin
        iclass    = IC_NOP;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        wb_sel    = WB_ALU;
        legal     = 1'b1;
        case (opcode)
            OPC_OP: begin
                iclass = IC_ALU;
            end
            OPC_OPIMM: begin
                iclass    = IC_ALU;
                alu_src_b = 1'b1;
            end
            OPC_AUIPC: begin
                iclass    = IC_ALU;
                alu_src_a = 1'b1;
                alu_src_b = 1'b1;
            end
            OPC_LUI: begin
                iclass    = IC_LUI;
                alu_src_b = 1'b1;
                wb_sel    = WB_IMM;
            end
            OPC_LOAD: begin
                iclass    = IC_LOAD;
                alu_src_b = 1'b1;
                wb_sel    = WB_LOAD;
            end
            OPC_STORE: begin
                iclass    = IC_STORE;
                alu_src_b = 1'b1;
            end
            // rs1 vs rs2 compare; the target comes from the PC adder
            OPC_BRANCH: begin
                iclass = IC_BRANCH;
            end
            OPC_JAL: begin
                iclass    = IC_JAL;
                alu_src_a = 1'b1;
                alu_src_b = 1'b1;
                wb_sel    = WB_PC4;
            end
            OPC_JALR: begin
                iclass    = IC_JALR;
                alu_src_b = 1'b1;
                wb_sel    = WB_PC4;
            end
            OPC_FENCE, OPC_SYSTEM: begin
                iclass = IC_NOP;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//   Control FSM of the multicycle RV32I core. Steps through
//   FETCH -> DECODE -> EXECUTE -> [MEM] -> [WB], driving per-state strobes to
//   the datapath, waiting on the memory ready handshakes and trapping on an
//   illegal opcode or a memory request that exceeds MEM_TIMEOUT wait cycles.
//
//   Parameters: MEM_TIMEOUT (wait cycles before timeout trap, >=1),
//               CNT_W (performance counter width).
//   Ports:
//     clk, resetn (synchronous, active-high: 1 = reset)
//     opcode, branch_taken, imem_ready, dmem_ready           inputs
//     imem_re, ir_we, pc_we, pc_sel, alu_src_a, alu_src_b,
//     dmem_re, dmem_we, rf_we, wb_sel                         datapath strobes
//     trap, trap_cause                                        error status
//     instret, cycles                                         perf counters
//
//   Build option: define CTRL_PERF_CNT_EN to implement instret/cycles;
//   otherwise both ports are tied to zero and no counter flops exist.
//
//   Strobes are decoded from the state register and gated with resetn, so a
//   reset asserted mid-instruction suppresses any rf/PC write in that cycle.
// ---------------------------------------------------------------------------
module multicycle_controller
    import rv32i_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_re,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             alu_src_a,
    output logic             alu_src_b,
    output logic             dmem_re,
    output logic             dmem_we,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret,
    output logic [CNT_W-1:0] cycles
);

    localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
    // Count value seen during the last permitted wait cycle
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    ctrl_state_t  state;
    trap_cause_t  cause_q;
    logic [TO_W-1:0] wait_cnt;

    logic [3:0]   dec_class_raw;
    instr_class_t dec_class;
    logic         dec_a, dec_b, dec_legal;
    logic [1:0]   dec_wb;

    ctrl_decoder u_dec (
        .opcode    (opcode),
        .iclass    (dec_class_raw),
        .alu_src_a (dec_a),
        .alu_src_b (dec_b),
        .wb_sel    (dec_wb),
        .legal     (dec_legal)
    );

    assign dec_class = instr_class_t'(dec_class_raw);

    // State register and wait counter. The counter defaults to zero on every
    // cycle so it is clear on entry to FETCH/MEM; it only advances while a
    // memory request is outstanding without ready.
    always_ff @(posedge clk) begin
        if (resetn) begin
            state    <= ST_FETCH;
            cause_q  <= TC_NONE;
            wait_cnt <= '0;
        end else begin
            wait_cnt <= '0;
            case (state)
                ST_FETCH: begin
                    if (imem_ready) begin
                        state <= ST_DECODE;
                    end else if (wait_cnt == TO_LAST) begin
                        state   <= ST_TRAP;
                        cause_q <= TC_IMEM_TO;
                    end else begin
                        wait_cnt <= wait_cnt + TO_W'(1);
                    end
                end
                ST_DECODE: begin
                    if (!dec_legal) begin
                        state   <= ST_TRAP;
                        cause_q <= TC_ILLEGAL;
                    end else begin
                        state <= ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    case (dec_class)
                        IC_BRANCH, IC_NOP: state <= ST_FETCH;
                        IC_LOAD, IC_STORE: state <= ST_MEM;
                        default:           state <= ST_WB;
                    endcase
                end
                ST_MEM: begin
                    if (dmem_ready) begin
                        state <= (dec_class == IC_LOAD) ? ST_WB : ST_FETCH;
                    end else if (wait_cnt == TO_LAST) begin
                        state   <= ST_TRAP;
                        cause_q <= TC_DMEM_TO;
                    end else begin
                        wait_cnt <= wait_cnt + TO_W'(1);
                    end
                end
                ST_WB: begin
                    state <= ST_FETCH;
                end
                ST_TRAP: begin
                    state <= ST_TRAP;
                end
                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end
    end

    // Strobe decode; everything is forced low while reset is asserted.
    always_comb begin
        imem_re    = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_sel     = PCS_PLUS4;
        alu_src_a  = 1'b0;
        alu_src_b  = 1'b0;
        dmem_re    = 1'b0;
        dmem_we    = 1'b0;
        rf_we      = 1'b0;
        wb_sel     = WB_ALU;
        trap       = 1'b0;
        trap_cause = TC_NONE;
        if (!resetn) begin
            case (state)
                ST_FETCH: begin
                    imem_re = 1'b1;
                    ir_we   = imem_ready;
                end
                ST_EXECUTE: begin
                    alu_src_a = dec_a;
                    alu_src_b = dec_b;
                    if (dec_class == IC_BRANCH) begin
                        pc_we  = 1'b1;
                        pc_sel = branch_taken ? PCS_BRANCH : PCS_PLUS4;
                    end else if (dec_class == IC_NOP) begin
                        pc_we = 1'b1;
                    end
                end
                ST_MEM: begin
                    if (dec_class == IC_LOAD) begin
                        dmem_re = 1'b1;
                    end else if (dec_class == IC_STORE) begin
                        dmem_we = 1'b1;
                        pc_we   = dmem_ready;
                    end
                end
                ST_WB: begin
                    rf_we  = 1'b1;
                    wb_sel = dec_wb;
                    pc_we  = 1'b1;
                    if (dec_class == IC_JAL) begin
                        pc_sel = PCS_BRANCH;
                    end else if (dec_class == IC_JALR) begin
                        pc_sel = PCS_JALR;
                    end
                end
                ST_TRAP: begin
                    trap       = 1'b1;
                    trap_cause = cause_q;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] cycles_q;
    logic [CNT_W-1:0] instret_q;

    // Both counters wrap naturally and hold their value once trapped.
    always_ff @(posedge clk) begin
        if (resetn) begin
            cycles_q  <= '0;
            instret_q <= '0;
        end else if (state != ST_TRAP) begin
            cycles_q <= cycles_q + CNT_W'(1);
            if (pc_we) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    assign cycles  = cycles_q;
    assign instret = instret_q;
`else
    assign cycles  = '0;
    assign instret = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    localparam logic [6:0] ADDI  = 7'b0010011;
    localparam logic [6:0] BEQ   = 7'b1100011;
    localparam logic [6:0] LW    = 7'b0000011;
    localparam logic [6:0] SW    = 7'b0100011;
    localparam logic [6:0] JAL   = 7'b1101111;
    localparam logic [6:0] JALR  = 7'b1100111;
    localparam logic [6:0] LUI   = 7'b0110111;
    localparam logic [6:0] FENCE = 7'b0001111;
    localparam logic [6:0] BAD   = 7'b1111111;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic [6:0]  opcode = 7'd0;
    logic        branch_taken = 1'b0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        imem_re, ir_we, pc_we, alu_src_a, alu_src_b;
    logic        dmem_re, dmem_we, rf_we, trap;
    logic [1:0]  pc_sel, wb_sel, trap_cause;
    logic [31:0] instret, cycles;

    multicycle_controller #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .clk(clk), .resetn(resetn), .opcode(opcode), .branch_taken(branch_taken),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_re(imem_re), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .dmem_re(dmem_re),
        .dmem_we(dmem_we), .rf_we(rf_we), .wb_sel(wb_sel), .trap(trap),
        .trap_cause(trap_cause), .instret(instret), .cycles(cycles)
    );

    always #5 clk = ~clk;

    // {imem_re, ir_we, pc_we, pc_sel, alu_a, alu_b, dmem_re, dmem_we, rf_we, wb_sel, trap, trap_cause}
    logic [14:0] outs;
    assign outs = {imem_re, ir_we, pc_we, pc_sel, alu_src_a, alu_src_b,
                   dmem_re, dmem_we, rf_we, wb_sel, trap, trap_cause};

    typedef struct packed {
        logic        rst;
        logic [6:0]  opc;
        logic        bt;
        logic        ir;
        logic        dr;
        logic [14:0] exp;
    } vec_t;

    vec_t  vt[$];
    string vn[$];
    int    nvec = 0;
    int    nerr = 0;

    function automatic logic [14:0] ov(input int ire, input int iwe, input int pwe,
                                       input int psel, input int a, input int b,
                                       input int dre, input int dwe, input int rwe,
                                       input int wsel, input int tr, input int tc);
        return {ire[0], iwe[0], pwe[0], psel[1:0], a[0], b[0],
                dre[0], dwe[0], rwe[0], wsel[1:0], tr[0], tc[1:0]};
    endfunction

    task automatic add(input string n, input int r, input logic [6:0] op, input int bt,
                       input int ir, input int dr, input logic [14:0] e);
        vec_t v;
        v.rst = r[0]; v.opc = op; v.bt = bt[0]; v.ir = ir[0]; v.dr = dr[0]; v.exp = e;
        vt.push_back(v);
        vn.push_back(n);
    endtask

    // One clock cycle: drive, sample at the falling edge, advance past the rising edge.
    task automatic apply(input string n, input int r, input logic [6:0] op, input int bt,
                         input int ir, input int dr, input logic [14:0] e);
        resetn = r[0]; opcode = op; branch_taken = bt[0];
        imem_ready = ir[0]; dmem_ready = dr[0];
        @(negedge clk);
        nvec++;
        if (outs !== e) begin
            nerr++;
            $display("FAIL %s: outputs=%b required=%b", n, outs, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string n, input logic [31:0] ei, input logic [31:0] ec);
        nvec++;
        if (instret !== ei || cycles !== ec) begin
            nerr++;
            $display("FAIL %s: instret=%0d cycles=%0d required instret=%0d cycles=%0d",
                     n, instret, cycles, ei, ec);
        end
    endtask

    initial begin
        logic [14:0] Z, OF, OFW, EXI, WBA;
        logic [31:0] exp_ir, exp_cy;
        Z   = '0;
        OF  = ov(1,1,0,0,0,0,0,0,0,0,0,0);   // fetch with ready
        OFW = ov(1,0,0,0,0,0,0,0,0,0,0,0);   // fetch waiting
        EXI = ov(0,0,0,0,0,1,0,0,0,0,0,0);   // execute, imm operand
        WBA = ov(0,0,1,0,0,0,0,0,1,0,0,0);   // WB of ALU result

        add("reset",     1, ADDI, 0,1,0, Z);
        add("addi.f",    0, ADDI, 0,1,0, OF);
        add("addi.d",    0, ADDI, 0,1,0, Z);
        add("addi.e",    0, ADDI, 0,0,0, EXI);
        add("addi.wb",   0, ADDI, 0,0,0, WBA);
        add("beqt.f",    0, BEQ,  0,1,0, OF);
        add("beqt.d",    0, BEQ,  0,0,0, Z);
        add("beqt.e",    0, BEQ,  1,0,0, ov(0,0,1,1,0,0,0,0,0,0,0,0));
        add("beqn.f",    0, BEQ,  0,1,0, OF);
        add("beqn.d",    0, BEQ,  0,0,0, Z);
        add("beqn.e",    0, BEQ,  0,0,0, ov(0,0,1,0,0,0,0,0,0,0,0,0));
        add("lw.f",      0, LW,   0,1,0, OF);
        add("lw.d",      0, LW,   0,0,1, Z);
        add("lw.e",      0, LW,   0,0,1, EXI);
        add("lw.m0",     0, LW,   0,0,0, ov(0,0,0,0,0,0,1,0,0,0,0,0));
        add("lw.m1",     0, LW,   0,0,0, ov(0,0,0,0,0,0,1,0,0,0,0,0));
        add("lw.m2",     0, LW,   0,0,0, ov(0,0,0,0,0,0,1,0,0,0,0,0));
        add("lw.m3",     0, LW,   0,0,1, ov(0,0,0,0,0,0,1,0,0,0,0,0));
        add("lw.wb",     0, LW,   0,0,0, ov(0,0,1,0,0,0,0,0,1,1,0,0));
        add("sw.f",      0, SW,   0,1,0, OF);
        add("sw.d",      0, SW,   0,0,0, Z);
        add("sw.e",      0, SW,   0,0,0, EXI);
        add("sw.m",      0, SW,   0,0,1, ov(0,0,1,0,0,0,0,1,0,0,0,0));
        add("jal.f",     0, JAL,  0,1,0, OF);
        add("jal.d",     0, JAL,  0,0,0, Z);
        add("jal.e",     0, JAL,  0,0,0, ov(0,0,0,0,1,1,0,0,0,0,0,0));
        add("jal.wb",    0, JAL,  0,0,0, ov(0,0,1,1,0,0,0,0,1,2,0,0));
        add("jalr.f",    0, JALR, 0,1,0, OF);
        add("jalr.d",    0, JALR, 0,0,0, Z);
        add("jalr.e",    0, JALR, 0,0,0, EXI);
        add("jalr.wb",   0, JALR, 0,0,0, ov(0,0,1,2,0,0,0,0,1,2,0,0));
        add("lui.f",     0, LUI,  0,1,0, OF);
        add("lui.d",     0, LUI,  0,0,0, Z);
        add("lui.e",     0, LUI,  0,0,0, EXI);
        add("lui.wb",    0, LUI,  0,0,0, ov(0,0,1,0,0,0,0,0,1,3,0,0));
        add("fence.f",   0, FENCE,0,1,0, OF);
        add("fence.d",   0, FENCE,0,0,0, Z);
        add("fence.e",   0, FENCE,0,0,0, ov(0,0,1,0,0,0,0,0,0,0,0,0));
        add("fw.f0",     0, ADDI, 0,0,0, OFW);
        add("fw.f1",     0, ADDI, 0,1,0, OF);
        add("fw.d",      0, ADDI, 0,0,0, Z);
        add("fw.e",      0, ADDI, 0,0,0, EXI);
        add("fw.wb",     0, ADDI, 0,0,1, WBA);
        add("ill.f",     0, BAD,  0,1,0, OF);
        add("ill.d",     0, BAD,  0,1,1, Z);
        add("ill.trap0", 0, BAD,  0,1,1, ov(0,0,0,0,0,0,0,0,0,0,1,1));
        add("ill.trap1", 0, BAD,  0,1,0, ov(0,0,0,0,0,0,0,0,0,0,1,1));
        add("ill.rst",   1, BAD,  0,1,0, Z);
        add("ill.fetch", 0, ADDI, 0,0,0, OFW);

        for (int i = 0; i < vt.size(); i++)
            apply(vn[i], vt[i].rst, vt[i].opc, vt[i].bt, vt[i].ir, vt[i].dr, vt[i].exp);

        // Instruction fetch timeout: 16 wait cycles, then trap with cause 2
        apply("ito.rst", 1, ADDI, 0,0,0, Z);
        for (int i = 0; i < 16; i++) apply("ito.wait", 0, ADDI, 0,0,0, OFW);
        apply("ito.trap", 0, ADDI, 0,0,0, ov(0,0,0,0,0,0,0,0,0,0,1,2));
        apply("ito.late", 0, ADDI, 0,1,0, ov(0,0,0,0,0,0,0,0,0,0,1,2));

        // Ready arriving in the last permitted wait cycle beats the timeout
        apply("rw.rst", 1, ADDI, 0,0,0, Z);
        for (int i = 0; i < 15; i++) apply("rw.wait", 0, ADDI, 0,0,0, OFW);
        apply("rw.ready", 0, ADDI, 0,1,0, OF);
        apply("rw.d",     0, ADDI, 0,0,0, Z);
        apply("rw.e",     0, ADDI, 0,0,0, EXI);

        // Data memory timeout on a load: cause 3, request drops
        apply("dto.rst", 1, LW, 0,0,0, Z);
        apply("dto.f",   0, LW, 0,1,0, OF);
        apply("dto.d",   0, LW, 0,0,0, Z);
        apply("dto.e",   0, LW, 0,0,0, EXI);
        for (int i = 0; i < 16; i++)
            apply("dto.wait", 0, LW, 0,0,0, ov(0,0,0,0,0,0,1,0,0,0,0,0));
        apply("dto.trap", 0, LW, 0,0,1, ov(0,0,0,0,0,0,0,0,0,0,1,3));

        // Ten zero-wait ADDIs, then a reset landing in WB
        apply("pc.rst", 1, ADDI, 0,0,0, Z);
        for (int i = 0; i < 10; i++) begin
            apply("pc.f",  0, ADDI, 0,1,0, OF);
            apply("pc.d",  0, ADDI, 0,0,0, Z);
            apply("pc.e",  0, ADDI, 0,0,0, EXI);
            apply("pc.wb", 0, ADDI, 0,0,0, WBA);
        end
`ifdef CTRL_PERF_CNT_EN
        exp_ir = 32'd10; exp_cy = 32'd40;
`else
        exp_ir = 32'd0;  exp_cy = 32'd0;
`endif
        chk_cnt("perf.10addi", exp_ir, exp_cy);
        apply("mwb.f",   0, ADDI, 0,1,0, OF);
        apply("mwb.d",   0, ADDI, 0,0,0, Z);
        apply("mwb.e",   0, ADDI, 0,0,0, EXI);
        apply("mwb.rst", 1, ADDI, 0,0,0, Z);
        chk_cnt("perf.cleared", 32'd0, 32'd0);
        apply("mwb.fetch", 0, ADDI, 0,1,0, OF);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
